// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the fetch controller.
// Provides AW (address/instruction width), the PC-register op encoding and the
// instruction-queue entry layout {inst, pc}.
package fetch_pkg;
    localparam int AW = 32;
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2,
        PC_REL  = 2'd3
    } pc_sel_e;
    typedef struct packed {
        logic [AW-1:0] inst;
        logic [AW-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, occupancy count and simultaneous push/pop.
// Ports: clk, rst (async, active-high); i_flush empties the FIFO and wins over push/pop;
// i_push/i_din write, i_pop removes the head; o_dout is the head, o_count the occupancy.
// Push while full is accepted only together with a pop.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd, r_wr;
    logic [CW-1:0]    r_cnt;
    logic             w_push, w_pop;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction
    assign w_pop   = i_pop & (r_cnt != '0);
    assign w_push  = i_push & ((r_cnt != CW'(DEPTH)) | w_pop);
    assign o_dout  = r_mem[r_rd];
    assign o_count = r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= w_push ? nxt(r_wr) : r_wr;
            r_rd  <= w_pop ? nxt(r_rd) : r_rd;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr] <= i_din;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-side controller between the PC register, instruction memory and decode.
// Ports: clk, rst (async, active-high)
//   PC register : i_pc_out (current PC), o_pc_sel (0 hold, 1 +4, 2 load, 3 +off*4+4), o_pc_in
//   imem request: o_imem_req_valid, i_imem_req_ready, o_imem_addr (= i_pc_out)
//   imem reply  : i_imem_rsp_valid, i_imem_rsp_data (in order, latency >= 1)
//   redirect    : i_redir_valid (pulse), i_redir_rel, i_redir_target
//   decode      : o_inst_valid, i_inst_ready, o_inst_data, o_inst_pc
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_pc_out,
    output logic [1:0]    o_pc_sel,
    output logic [AW-1:0] o_pc_in,
    output logic          o_imem_req_valid,
    input  logic          i_imem_req_ready,
    output logic [AW-1:0] o_imem_addr,
    input  logic          i_imem_rsp_valid,
    input  logic [AW-1:0] i_imem_rsp_data,
    input  logic          i_redir_valid,
    input  logic          i_redir_rel,
    input  logic [AW-1:0] i_redir_target,
    output logic          o_inst_valid,
    input  logic          i_inst_ready,
    output logic [AW-1:0] o_inst_data,
    output logic [AW-1:0] o_inst_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(2 * DEPTH + 1);
    logic          w_redir, w_fire, w_rsp_ok, w_pop;
    logic [CW-1:0] w_outstanding, w_qcount;
    logic [AW-1:0] w_pend_pc;
    fetch_entry_t  w_head;
    logic [DW-1:0] r_drop;
    logic [DW:0]   w_drop_sum;
    // Outputs are gated by rst so they fall to reset values without waiting for a clock.
    assign w_redir          = i_redir_valid & ~rst;
    assign o_imem_req_valid = ~rst & ~i_redir_valid &
                              (({1'b0, w_qcount} + {1'b0, w_outstanding}) < (CW+1)'(DEPTH));
    assign w_fire           = o_imem_req_valid & i_imem_req_ready;
    assign o_imem_addr      = i_pc_out;
    assign o_pc_sel         = w_redir ? (i_redir_rel ? PC_REL : PC_LOAD) : (w_fire ? PC_INC : PC_HOLD);
    assign o_pc_in          = w_redir ? i_redir_target : '0;
    // Responses still owed to a flushed stream are discarded before any new one is accepted.
    assign w_rsp_ok         = i_imem_rsp_valid & ~w_redir & (r_drop == '0) & (w_outstanding != '0);
    assign w_pop            = o_inst_valid & i_inst_ready & ~w_redir;
    // A response landing in the redirect cycle consumes one of the owed responses itself.
    assign w_drop_sum       = {1'b0, r_drop} + (DW+1)'(w_outstanding) -
                              (DW+1)'(i_imem_rsp_valid & ((r_drop != '0) | (w_outstanding != '0)));
    assign o_inst_valid     = w_qcount != '0;
    assign o_inst_data      = w_head.inst;
    assign o_inst_pc        = w_head.pc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_drop <= '0;
        else if (w_redir) r_drop <= (w_drop_sum > (DW+1)'(2 * DEPTH)) ? DW'(2 * DEPTH) : w_drop_sum[DW-1:0];
        else if (i_imem_rsp_valid && r_drop != '0) r_drop <= r_drop - DW'(1);
    end
    // The pending-PC occupancy is the outstanding-request count.
    fetch_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_pend (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_redir),
        .i_push  (w_fire),
        .i_din   (i_pc_out),
        .i_pop   (w_rsp_ok),
        .o_dout  (w_pend_pc),
        .o_count (w_outstanding)
    );
    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_redir),
        .i_push  (w_rsp_ok),
        .i_din   ({i_imem_rsp_data, w_pend_pc}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_qcount)
    );
    a_rsp_protocol: assert property (@(posedge clk) disable iff (rst)
        !(i_imem_rsp_valid && !i_redir_valid && r_drop == '0 && w_outstanding == '0));
    a_drop_sat: assert property (@(posedge clk) disable iff (rst)
        !(i_redir_valid && w_drop_sum > (DW+1)'(2 * DEPTH)));
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl with a PC-register model and an in-order memory model.
module tb_fetch_ctrl;
    import fetch_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_pc_out = '0;
    logic [1:0]  o_pc_sel;
    logic [31:0] o_pc_in;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b0;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic        i_redir_valid = 1'b0;
    logic        i_redir_rel = 1'b0;
    logic [31:0] i_redir_target = '0;
    logic        o_inst_valid;
    logic        i_inst_ready = 1'b0;
    logic [31:0] o_inst_data;
    logic [31:0] o_inst_pc;
    int          n_chk = 0;
    int          n_pass = 0;
    int          lat = 1;
    int          cyc = 0;
    logic [31:0] mq_a[$];
    int          mq_t[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    fetch_ctrl #(.DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_pc_out         (i_pc_out),
        .o_pc_sel         (o_pc_sel),
        .o_pc_in          (o_pc_in),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redir_valid    (i_redir_valid),
        .i_redir_rel      (i_redir_rel),
        .i_redir_target   (i_redir_target),
        .o_inst_valid     (o_inst_valid),
        .i_inst_ready     (i_inst_ready),
        .o_inst_data      (o_inst_data),
        .o_inst_pc        (o_inst_pc)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) i_pc_out <= '0;
        else if (o_pc_sel == PC_INC) i_pc_out <= i_pc_out + 32'd4;
        else if (o_pc_sel == PC_LOAD) i_pc_out <= o_pc_in;
        else if (o_pc_sel == PC_REL) i_pc_out <= i_pc_out + (o_pc_in << 2) + 32'd4;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq_a.delete();
            mq_t.delete();
            cyc <= 0;
            i_imem_rsp_valid <= 1'b0;
            i_imem_rsp_data <= '0;
        end else begin
            cyc <= cyc + 1;
            if (o_imem_req_valid && i_imem_req_ready) begin
                mq_a.push_back(o_imem_addr);
                mq_t.push_back(cyc + lat - 1);
            end
            if (mq_t.size() > 0 && mq_t[0] <= cyc) begin
                i_imem_rsp_valid <= 1'b1;
                i_imem_rsp_data <= mem_word(mq_a[0]);
                void'(mq_a.pop_front());
                void'(mq_t.pop_front());
            end else begin
                i_imem_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        i_imem_req_ready = 1'b0;
        i_inst_ready = 1'b0;
        i_redir_valid = 1'b0;
        i_redir_rel = 1'b0;
        i_redir_target = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_stream(input int n, input logic [31:0] a0, input string tag);
        int nreq = 0;
        logic [31:0] na = a0;
        logic [31:0] e;
        for (int c = 0; c < 60 && (nreq < n || exp_q.size() != 0); c++) begin
            @(negedge clk);
            i_redir_valid = 1'b0;
            i_redir_rel = 1'b0;
            i_inst_ready = 1'b1;
            i_imem_req_ready = (nreq < n);
            #1;
            if (o_imem_req_valid && i_imem_req_ready) begin
                n_chk++;
                if (o_imem_addr !== na) $display("FAIL %s_addr: got %h want %h", tag, o_imem_addr, na);
                else n_pass++;
                n_chk++;
                if (o_pc_sel !== PC_INC) $display("FAIL %s_sel: got %0d want %0d", tag, o_pc_sel, PC_INC);
                else n_pass++;
                na += 32'd4;
                nreq++;
            end
            if (o_inst_valid) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s_extra: got inst_pc %h want no instruction", tag, o_inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (o_inst_pc !== e) $display("FAIL %s_pc: got %h want %h", tag, o_inst_pc, e);
                    else n_pass++;
                    n_chk++;
                    if (o_inst_data !== mem_word(e))
                        $display("FAIL %s_data: got %h want %h", tag, o_inst_data, mem_word(e));
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (nreq != n || exp_q.size() != 0)
            $display("FAIL %s_timeout: got %0d req %0d left want %0d req 0 left", tag, nreq, exp_q.size(), n);
        else n_pass++;
        i_imem_req_ready = 1'b0;
        i_inst_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_imem_req_ready = 1'b1;
        i_inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (o_pc_sel !== PC_HOLD) $display("FAIL rst_sel: got %0d want 0", o_pc_sel); else n_pass++;
        n_chk++; if (o_pc_in !== 32'd0) $display("FAIL rst_pc_in: got %h want 0", o_pc_in); else n_pass++;
        n_chk++; if (o_imem_req_valid !== 1'b0) $display("FAIL rst_req: got %b want 0", o_imem_req_valid); else n_pass++;
        n_chk++; if (o_inst_valid !== 1'b0) $display("FAIL rst_inst: got %b want 0", o_inst_valid); else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++; if (o_imem_req_valid !== 1'b1) $display("FAIL rel_req: got %b want 1", o_imem_req_valid); else n_pass++;
        n_chk++; if (o_imem_addr !== 32'd0) $display("FAIL rel_addr: got %h want 0", o_imem_addr); else n_pass++;
        n_chk++; if (o_pc_sel !== PC_INC) $display("FAIL rel_sel: got %0d want 1", o_pc_sel); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        run_stream(6, 32'd0, "stream");
    endtask

    task automatic test_backpressure();
        int nf = 0;
        logic [31:0] na = '0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            i_imem_req_ready = 1'b1;
            #1;
            if (o_imem_req_valid && i_imem_req_ready) begin
                n_chk++; if (o_imem_addr !== na) $display("FAIL bp_addr: got %h want %h", o_imem_addr, na); else n_pass++;
                na += 32'd4;
                nf++;
            end
        end
        n_chk++; if (nf != 2) $display("FAIL bp_count: got %0d want 2", nf); else n_pass++;
        n_chk++; if (o_imem_req_valid !== 1'b0) $display("FAIL bp_req: got %b want 0", o_imem_req_valid); else n_pass++;
        n_chk++; if (o_pc_sel !== PC_HOLD) $display("FAIL bp_sel: got %0d want 0", o_pc_sel); else n_pass++;
        n_chk++; if (o_pc_in !== 32'd0) $display("FAIL bp_pc_in: got %h want 0", o_pc_in); else n_pass++;
        n_chk++; if (o_inst_pc !== 32'd0) $display("FAIL bp_head0: got %h want 0", o_inst_pc); else n_pass++;
        @(negedge clk);
        i_inst_ready = 1'b1;
        #1;
        nf = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            i_inst_ready = 1'b0;
            #1;
            if (o_imem_req_valid && i_imem_req_ready) begin
                n_chk++; if (o_imem_addr !== 32'd8) $display("FAIL bp_refill_addr: got %h want 8", o_imem_addr); else n_pass++;
                nf++;
            end
        end
        n_chk++; if (nf != 1) $display("FAIL bp_refill_count: got %0d want 1", nf); else n_pass++;
        n_chk++; if (o_inst_pc !== 32'd4) $display("FAIL bp_head1: got %h want 4", o_inst_pc); else n_pass++;
    endtask

    task automatic test_redirect_abs();
        logic found = 1'b0;
        do_reset();
        lat = 3;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            i_imem_req_ready = 1'b1;
            i_inst_ready = 1'b1;
            #1;
            if (mq_a.size() == 2 && !i_imem_rsp_valid) found = 1'b1;
        end
        n_chk++; if (!found) $display("FAIL abs_two_outstanding: got %0d in flight want 2", mq_a.size()); else n_pass++;
        i_redir_valid = 1'b1;
        i_redir_rel = 1'b0;
        i_redir_target = 32'h100;
        i_imem_req_ready = 1'b0;
        #1;
        n_chk++; if (o_pc_sel !== PC_LOAD) $display("FAIL abs_sel: got %0d want 2", o_pc_sel); else n_pass++;
        n_chk++; if (o_pc_in !== 32'h100) $display("FAIL abs_pc_in: got %h want 100", o_pc_in); else n_pass++;
        n_chk++; if (o_imem_req_valid !== 1'b0) $display("FAIL abs_req: got %b want 0", o_imem_req_valid); else n_pass++;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        run_stream(2, 32'h100, "abs");
        lat = 1;
    endtask

    task automatic test_redirect_rel();
        do_reset();
        @(negedge clk);
        i_redir_valid = 1'b1;
        i_redir_rel = 1'b0;
        i_redir_target = 32'h40;
        @(negedge clk);
        i_redir_rel = 1'b1;
        i_redir_target = 32'hFFFF_FFFE;
        #1;
        n_chk++; if (o_pc_sel !== PC_REL) $display("FAIL rel_sel: got %0d want 3", o_pc_sel); else n_pass++;
        n_chk++; if (o_pc_in !== 32'hFFFF_FFFE) $display("FAIL rel_pc_in: got %h want fffffffe", o_pc_in); else n_pass++;
        n_chk++; if (o_imem_addr !== 32'h40) $display("FAIL rel_base: got %h want 40", o_imem_addr); else n_pass++;
        exp_q.push_back(32'h3C);
        exp_q.push_back(32'h40);
        run_stream(2, 32'h3C, "rel");
    endtask

    task automatic test_redirect_collide();
        logic found = 1'b0;
        do_reset();
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            i_imem_req_ready = 1'b1;
            #1;
            if (o_inst_valid && i_imem_rsp_valid) found = 1'b1;
        end
        n_chk++; if (!found) $display("FAIL col_setup: got inst_valid %b rsp %b want 1 1", o_inst_valid, i_imem_rsp_valid); else n_pass++;
        i_redir_valid = 1'b1;
        i_redir_rel = 1'b0;
        i_redir_target = 32'h200;
        i_imem_req_ready = 1'b0;
        i_inst_ready = 1'b1;
        #1;
        n_chk++; if (o_pc_sel !== PC_LOAD) $display("FAIL col_sel: got %0d want 2", o_pc_sel); else n_pass++;
        @(negedge clk);
        i_redir_valid = 1'b0;
        i_inst_ready = 1'b0;
        #1;
        n_chk++; if (o_inst_valid !== 1'b0) $display("FAIL col_empty: got %b want 0", o_inst_valid); else n_pass++;
        @(negedge clk);
        #1;
        n_chk++; if (o_inst_valid !== 1'b0) $display("FAIL col_still_empty: got %b want 0", o_inst_valid); else n_pass++;
        n_chk++; if (o_imem_addr !== 32'h200) $display("FAIL col_addr: got %h want 200", o_imem_addr); else n_pass++;
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        run_stream(2, 32'h200, "col");
    endtask

    task automatic test_async_reset();
        logic found = 1'b0;
        do_reset();
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            i_imem_req_ready = 1'b1;
            #1;
            if (o_inst_valid && !o_imem_req_valid && !i_imem_rsp_valid) found = 1'b1;
        end
        n_chk++; if (!found) $display("FAIL ar_full: got inst_valid %b req %b want 1 0", o_inst_valid, o_imem_req_valid); else n_pass++;
        #2;
        rst = 1'b1;
        i_imem_req_ready = 1'b0;
        #1;
        n_chk++; if (o_inst_valid !== 1'b0) $display("FAIL ar_inst: got %b want 0", o_inst_valid); else n_pass++;
        n_chk++; if (o_imem_req_valid !== 1'b0) $display("FAIL ar_req: got %b want 0", o_imem_req_valid); else n_pass++;
        n_chk++; if (o_pc_sel !== PC_HOLD) $display("FAIL ar_sel: got %0d want 0", o_pc_sel); else n_pass++;
        n_chk++; if (o_pc_in !== 32'd0) $display("FAIL ar_pc_in: got %h want 0", o_pc_in); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd4);
        run_stream(2, 32'd0, "ar");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_abs();
        test_redirect_rel();
        test_redirect_collide();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end by 100000 want finish");
        $fatal(1);
    end
endmodule
